note_sequencer: RTL and testbench

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/melody_pkg.sv | 15 +
 rtl/note_ram.sv | 28 ++
 rtl/note_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_note_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody note sequencer and its note table.
package melody_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } seq_state_t;

    localparam int DEF_PW = 5;
    localparam int DEF_DW = 13;
    localparam int REST   = 0;

endpackage

// File: rtl/note_ram.sv
// Note table: one write port and a registered read port that returns the old
// word when the same address is written on the same edge.
module note_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 18,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a table of (pitch, duration) notes, driving the sine clkgen
// divider and DAC gate; durations and gaps are counted in fs_tick strobes.
module note_sequencer
    import melody_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int PW        = DEF_PW,
    parameter int DW        = DEF_DW,
    parameter int GAP_TICKS = 1,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fs_tick,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [PW-1:0] wr_pitch,
    input  logic [DW-1:0] wr_dur,
    input  logic [AW-1:0] last_idx,
    input  logic          loop_en,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic [PW-1:0] pitch_maxval,
    output logic          tone_en,
    output logic          note_strobe,
    output logic [AW-1:0] note_idx,
    output logic          done
);

    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TICKS > 0) ? GAP_W'(GAP_TICKS - 1) : '0;

    seq_state_t       state_reg, state_next;
    logic [AW-1:0]    note_idx_reg, idx_next;
    logic [PW-1:0]    pitch_reg;
    logic             tone_en_reg, note_strobe_reg, done_reg;
    logic [DW-1:0]    dur_reg, dur_cnt_reg, dur_last;
    logic [GAP_W-1:0] gap_cnt_reg;

    logic             enter_play, enter_gap, song_end, cnt_inc, gap_inc, advance;
    logic             rd_en;
    logic [PW+DW-1:0] rd_data;
    logic [PW-1:0]    rd_pitch;
    logic [DW-1:0]    rd_dur;

    // The read is issued on the edge that enters LOAD so the entry is valid
    // during LOAD and can be registered into the outputs on the way to PLAY.
    note_ram #(
        .DEPTH (DEPTH),
        .WIDTH (PW + DW)
    ) u_note_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({wr_pitch, wr_dur}),
        .rd_en   (rd_en),
        .rd_addr (idx_next),
        .rd_data (rd_data)
    );

    assign rd_pitch = rd_data[PW+DW-1:DW];
    assign rd_dur   = rd_data[DW-1:0];
    assign rd_en    = (state_next == ST_LOAD);
    assign dur_last = (dur_reg == '0) ? '0 : dur_reg - 1'b1;

    always_comb begin
        state_next = state_reg;
        idx_next   = note_idx_reg;
        enter_play = 1'b0;
        enter_gap  = 1'b0;
        song_end   = 1'b0;
        cnt_inc    = 1'b0;
        gap_inc    = 1'b0;
        advance    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    idx_next   = '0;
                end
            end
            ST_LOAD: begin
                state_next = ST_PLAY;
                enter_play = 1'b1;
            end
            ST_PLAY: begin
                if (fs_tick) begin
                    if (dur_cnt_reg == dur_last) begin
                        if (GAP_TICKS > 0) begin
                            state_next = ST_GAP;
                            enter_gap  = 1'b1;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (fs_tick) begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        advance = 1'b1;
                    end else begin
                        gap_inc = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Any index other than last_idx steps forward with a wrap at the
        // table end, so an out-of-range last_idx just keeps cycling.
        if (advance) begin
            if (note_idx_reg != last_idx) begin
                idx_next   = (note_idx_reg == AW'(DEPTH - 1)) ? '0 : note_idx_reg + 1'b1;
                state_next = ST_LOAD;
            end else if (loop_en) begin
                idx_next   = '0;
                state_next = ST_LOAD;
            end else begin
                state_next = ST_IDLE;
                song_end   = 1'b1;
            end
        end

        if (stop) begin
            state_next = ST_IDLE;
            idx_next   = note_idx_reg;
            enter_play = 1'b0;
            enter_gap  = 1'b0;
            song_end   = 1'b0;
            cnt_inc    = 1'b0;
            gap_inc    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            note_idx_reg    <= '0;
            pitch_reg       <= '0;
            tone_en_reg     <= 1'b0;
            note_strobe_reg <= 1'b0;
            done_reg        <= 1'b0;
            dur_reg         <= '0;
            dur_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            note_idx_reg    <= idx_next;
            note_strobe_reg <= enter_play;
            done_reg        <= song_end;

            if (enter_play) begin
                dur_reg     <= rd_dur;
                dur_cnt_reg <= '0;
                tone_en_reg <= (rd_pitch != PW'(REST));
                if (rd_pitch != PW'(REST)) begin
                    pitch_reg <= rd_pitch;
                end
            end else begin
                if (cnt_inc) begin
                    dur_cnt_reg <= dur_cnt_reg + 1'b1;
                end
                if (enter_gap || song_end || stop) begin
                    tone_en_reg <= 1'b0;
                end
            end

            if (enter_gap) begin
                gap_cnt_reg <= '0;
            end else if (gap_inc) begin
                gap_cnt_reg <= gap_cnt_reg + 1'b1;
            end
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign pitch_maxval = pitch_reg;
    assign tone_en      = tone_en_reg;
    assign note_strobe  = note_strobe_reg;
    assign note_idx     = note_idx_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: one instance without and one with an
// articulation gap, sharing all inputs; fs_tick strobes every fourth cycle.
module tb_note_sequencer;

    logic        clk, reset, fs_tick, wr_en, loop_en, start, stop;
    logic [4:0]  wr_addr, last_idx, wr_pitch;
    logic [12:0] wr_dur;
    logic        busy [2];
    logic        tone_en [2];
    logic        note_strobe [2];
    logic        done [2];
    logic [4:0]  pitch_maxval [2];
    logic [4:0]  note_idx [2];

    int cyc, tests_run, tests_failed;

    note_sequencer #(.GAP_TICKS(0)) dut0 (
        .clk(clk), .reset(reset), .fs_tick(fs_tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_dur(wr_dur),
        .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop),
        .busy(busy[0]), .pitch_maxval(pitch_maxval[0]), .tone_en(tone_en[0]),
        .note_strobe(note_strobe[0]), .note_idx(note_idx[0]), .done(done[0])
    );

    note_sequencer #(.GAP_TICKS(1)) dut1 (
        .clk(clk), .reset(reset), .fs_tick(fs_tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_pitch(wr_pitch), .wr_dur(wr_dur),
        .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop),
        .busy(busy[1]), .pitch_maxval(pitch_maxval[1]), .tone_en(tone_en[1]),
        .note_strobe(note_strobe[1]), .note_idx(note_idx[1]), .done(done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        fs_tick = (cyc % 4 == 0);
    endtask

    task automatic write_note(input int addr, input int p, input int d);
        wr_en    = 1'b1;
        wr_addr  = 5'(addr);
        wr_pitch = 5'(p);
        wr_dur   = 13'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic idle_all();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic start_song();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // From a note_strobe cycle, count fs ticks with tone on/off until the next
    // note_strobe or the end of the song.
    task automatic measure(input int d, output int on_t, output int off_t);
        int n;
        on_t = 0; off_t = 0; n = 0;
        do begin
            if (fs_tick && tone_en[d]) on_t++;
            else if (fs_tick) off_t++;
            step();
            n++;
        end while (!note_strobe[d] && busy[d] && n < 200);
        tests_run++;
        if (n >= 200) begin
            tests_failed++;
            $display("FAIL measure_timeout dut%0d: ran %0d cycles, required < 200", d, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        for (int d = 0; d < 2; d++) begin
            tests_run++; if (busy[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_busy dut%0d: got %0b, want 0", d, busy[d]); end
            tests_run++; if (tone_en[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_tone dut%0d: got %0b, want 0", d, tone_en[d]); end
            tests_run++; if (note_strobe[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_strobe dut%0d: got %0b, want 0", d, note_strobe[d]); end
            tests_run++; if (done[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_done dut%0d: got %0b, want 0", d, done[d]); end
            tests_run++; if (pitch_maxval[d] !== 5'd0) begin tests_failed++; $display("FAIL reset_pitch dut%0d: got %0d, want 0", d, pitch_maxval[d]); end
            tests_run++; if (note_idx[d] !== 5'd0) begin tests_failed++; $display("FAIL reset_idx dut%0d: got %0d, want 0", d, note_idx[d]); end
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int on_t, off_t;
        idle_all();
        write_note(0, 18, 2);
        write_note(1, 13, 1);
        last_idx = 5'd1; loop_en = 1'b0;
        start_song();
        tests_run++; if (busy[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_t1: got %0b, want 1", busy[0]); end
        tests_run++; if (note_strobe[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_strobe_t1: got %0b, want 0", note_strobe[0]); end
        step();
        tests_run++; if (note_strobe[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_strobe_t2: got %0b, want 1", note_strobe[0]); end
        tests_run++; if (pitch_maxval[0] !== 5'd18) begin tests_failed++; $display("FAIL basic_pitch0: got %0d, want 18", pitch_maxval[0]); end
        tests_run++; if (tone_en[0] !== 1'b1) begin tests_failed++; $display("FAIL basic_tone0: got %0b, want 1", tone_en[0]); end
        measure(0, on_t, off_t);
        tests_run++; if (on_t != 2 || off_t != 0) begin tests_failed++; $display("FAIL basic_ticks0: got on=%0d off=%0d, want on=2 off=0", on_t, off_t); end
        tests_run++; if (note_strobe[0] !== 1'b1 || pitch_maxval[0] !== 5'd13 || note_idx[0] !== 5'd1) begin tests_failed++; $display("FAIL basic_note1: got strobe=%0b pitch=%0d idx=%0d, want 1/13/1", note_strobe[0], pitch_maxval[0], note_idx[0]); end
        measure(0, on_t, off_t);
        tests_run++; if (on_t != 1 || off_t != 0) begin tests_failed++; $display("FAIL basic_ticks1: got on=%0d off=%0d, want on=1 off=0", on_t, off_t); end
        tests_run++; if (done[0] !== 1'b1 || busy[0] !== 1'b0 || tone_en[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_end: got done=%0b busy=%0b tone=%0b, want 1/0/0", done[0], busy[0], tone_en[0]); end
        step();
        tests_run++; if (done[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %0b, want 0", done[0]); end
    endtask

    task automatic test_rest();
        int on_t, off_t;
        idle_all();
        write_note(0, 7, 1);
        write_note(1, 0, 3);
        write_note(2, 9, 1);
        last_idx = 5'd2; loop_en = 1'b0;
        start_song();
        step();
        measure(0, on_t, off_t);
        tests_run++; if (note_strobe[0] !== 1'b1 || tone_en[0] !== 1'b0 || pitch_maxval[0] !== 5'd7) begin tests_failed++; $display("FAIL rest_entry: got strobe=%0b tone=%0b pitch=%0d, want 1/0/7", note_strobe[0], tone_en[0], pitch_maxval[0]); end
        measure(0, on_t, off_t);
        tests_run++; if (on_t != 0 || off_t != 3) begin tests_failed++; $display("FAIL rest_ticks: got on=%0d off=%0d, want on=0 off=3", on_t, off_t); end
        tests_run++; if (pitch_maxval[0] !== 5'd9 || tone_en[0] !== 1'b1) begin tests_failed++; $display("FAIL rest_next: got pitch=%0d tone=%0b, want 9/1", pitch_maxval[0], tone_en[0]); end
        measure(0, on_t, off_t);
        tests_run++; if (done[0] !== 1'b1) begin tests_failed++; $display("FAIL rest_done: got %0b, want 1", done[0]); end
    endtask

    task automatic test_loop();
        int on_t, off_t;
        idle_all();
        last_idx = 5'd2; loop_en = 1'b1;
        start_song();
        step();
        for (int k = 0; k < 5; k++) begin
            tests_run++; if (note_strobe[0] !== 1'b1 || note_idx[0] !== 5'(k % 3)) begin tests_failed++; $display("FAIL loop_idx%0d: got strobe=%0b idx=%0d, want 1/%0d", k, note_strobe[0], note_idx[0], k % 3); end
            if (k < 4) begin
                measure(0, on_t, off_t);
                tests_run++; if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin tests_failed++; $display("FAIL loop_running%0d: got done=%0b busy=%0b, want 0/1", k, done[0], busy[0]); end
            end
        end
        loop_en = 1'b0;
    endtask

    task automatic test_gap();
        int on_t, off_t;
        idle_all();
        write_note(0, 11, 4);
        write_note(1, 12, 1);
        last_idx = 5'd1; loop_en = 1'b0;
        start_song();
        step();
        tests_run++; if (note_strobe[1] !== 1'b1 || pitch_maxval[1] !== 5'd11) begin tests_failed++; $display("FAIL gap_first: got strobe=%0b pitch=%0d, want 1/11", note_strobe[1], pitch_maxval[1]); end
        measure(1, on_t, off_t);
        tests_run++; if (on_t != 4 || off_t != 1) begin tests_failed++; $display("FAIL gap_ticks0: got on=%0d off=%0d, want on=4 off=1", on_t, off_t); end
        tests_run++; if (note_strobe[1] !== 1'b1 || pitch_maxval[1] !== 5'd12) begin tests_failed++; $display("FAIL gap_second: got strobe=%0b pitch=%0d, want 1/12", note_strobe[1], pitch_maxval[1]); end
        measure(1, on_t, off_t);
        tests_run++; if (on_t != 1 || off_t != 1 || done[1] !== 1'b1) begin tests_failed++; $display("FAIL gap_end: got on=%0d off=%0d done=%0b, want 1/1/1", on_t, off_t, done[1]); end
    endtask

    task automatic test_stop();
        int on_t, off_t;
        logic seen;
        idle_all();
        write_note(0, 11, 1);
        write_note(1, 12, 1);
        last_idx = 5'd1; loop_en = 1'b1;
        start_song();
        step();
        measure(0, on_t, off_t);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        tests_run++; if (busy[0] !== 1'b0 || tone_en[0] !== 1'b0 || done[0] !== 1'b0) begin tests_failed++; $display("FAIL stop_idle: got busy=%0b tone=%0b done=%0b, want 0/0/0", busy[0], tone_en[0], done[0]); end
        tests_run++; if (note_idx[0] !== 5'd1) begin tests_failed++; $display("FAIL stop_idx: got %0d, want 1", note_idx[0]); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen = seen | busy[0] | done[0];
        end
        tests_run++; if (seen !== 1'b0) begin tests_failed++; $display("FAIL stop_quiet: got busy/done activity=%0b, want 0", seen); end
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        tests_run++; if (busy[0] !== 1'b0 || busy[1] !== 1'b0 || tone_en[0] !== 1'b0) begin tests_failed++; $display("FAIL startstop_idle: got busy0=%0b busy1=%0b tone=%0b, want 0/0/0", busy[0], busy[1], tone_en[0]); end
        step(); step();
        tests_run++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin tests_failed++; $display("FAIL startstop_stays: got busy=%0b done=%0b, want 0/0", busy[0], done[0]); end
        loop_en = 1'b0;
    endtask

    task automatic test_read_first();
        int on_t, off_t;
        idle_all();
        write_note(0, 20, 1);
        last_idx = 5'd0; loop_en = 1'b0;
        start_song();
        wr_en = 1'b1; wr_addr = 5'd0; wr_pitch = 5'd21; wr_dur = 13'd0;
        step();
        wr_en = 1'b0;
        tests_run++; if (note_strobe[0] !== 1'b1 || pitch_maxval[0] !== 5'd20) begin tests_failed++; $display("FAIL readfirst_old: got strobe=%0b pitch=%0d, want 1/20", note_strobe[0], pitch_maxval[0]); end
        measure(0, on_t, off_t);
        idle_all();
        start_song();
        step();
        tests_run++; if (pitch_maxval[0] !== 5'd21) begin tests_failed++; $display("FAIL readfirst_new: got %0d, want 21", pitch_maxval[0]); end
        measure(0, on_t, off_t);
        tests_run++; if (on_t != 1 || done[0] !== 1'b1) begin tests_failed++; $display("FAIL dur_zero: got on=%0d done=%0b, want 1/1", on_t, done[0]); end
    endtask

    task automatic test_reset_mid();
        int on_t, off_t;
        idle_all();
        write_note(0, 5, 2);
        write_note(1, 6, 2);
        last_idx = 5'd1; loop_en = 1'b0;
        start_song();
        step();
        measure(0, on_t, off_t);
        step();
        #2 reset = 1'b0;
        #1;
        tests_run++; if (busy[0] !== 1'b0 || tone_en[0] !== 1'b0) begin tests_failed++; $display("FAIL async_reset_ctl: got busy=%0b tone=%0b, want 0/0", busy[0], tone_en[0]); end
        tests_run++; if (note_idx[0] !== 5'd0 || pitch_maxval[0] !== 5'd0) begin tests_failed++; $display("FAIL async_reset_data: got idx=%0d pitch=%0d, want 0/0", note_idx[0], pitch_maxval[0]); end
        step(); step();
        reset = 1'b1;
        step();
        start_song();
        step();
        tests_run++; if (note_strobe[0] !== 1'b1 || note_idx[0] !== 5'd0 || pitch_maxval[0] !== 5'd5) begin tests_failed++; $display("FAIL restart: got strobe=%0b idx=%0d pitch=%0d, want 1/0/5", note_strobe[0], note_idx[0], pitch_maxval[0]); end
        measure(0, on_t, off_t);
        tests_run++; if (on_t != 2 || pitch_maxval[0] !== 5'd6) begin tests_failed++; $display("FAIL restart_table: got on=%0d pitch=%0d, want 2/6", on_t, pitch_maxval[0]); end
    endtask

    initial begin
        cyc = 0; tests_run = 0; tests_failed = 0;
        reset = 1'b0; fs_tick = 1'b0; wr_en = 1'b0; loop_en = 1'b0;
        start = 1'b0; stop = 1'b0;
        wr_addr = '0; last_idx = '0; wr_pitch = '0; wr_dur = '0;
        test_reset();
        test_basic();
        test_rest();
        test_loop();
        test_gap();
        test_stop();
        test_read_first();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
